// File: rtl/line_mem_responder.sv
// Line-addressed backing memory answering the cache controller's 128-bit refill/write-back
// interface with programmable read/write latency and single-cycle completion pulses.
module line_mem_responder #(
    parameter int LINE_WIDTH = 128,
    parameter int INDEX_BITS = 10,
    parameter int RD_LATENCY = 4,
    parameter int WR_LATENCY = 3,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  mem_read,
    input  logic [31:0]           mem_read_addr,
    input  logic                  mem_write,
    input  logic [31:0]           mem_write_addr,
    input  logic [LINE_WIDTH-1:0] mem_wr_data,
    output logic [LINE_WIDTH-1:0] mem_rd_data,
    output logic                  mem_rd_data_valid,
    output logic                  mem_wr_data_ready,
    output logic                  busy,
    output logic [CNT_WIDTH-1:0]  rd_count,
    output logic [CNT_WIDTH-1:0]  wr_count
);

    typedef enum logic [2:0] {IDLE, WR_WAIT, WR_RESP, RD_WAIT, RD_RESP} state_t;

    localparam int MAX_LAT = (RD_LATENCY > WR_LATENCY) ? RD_LATENCY : WR_LATENCY;
    localparam int LAT_W   = (MAX_LAT > 1) ? $clog2(MAX_LAT) : 1;
    localparam logic [LAT_W-1:0] RD_LOAD = LAT_W'(RD_LATENCY - 1);
    localparam logic [LAT_W-1:0] WR_LOAD = LAT_W'(WR_LATENCY - 1);
    localparam logic [LAT_W-1:0] LAT_ONE = LAT_W'(1);

    state_t                  state;
    logic [LAT_W-1:0]        lat_cnt;
    logic [INDEX_BITS-1:0]   rd_idx_in, wr_idx_in;
    logic [INDEX_BITS-1:0]   rd_idx_q, wr_idx_q;
    logic [LINE_WIDTH-1:0]   wr_data_q;
    logic                    accept_wr, accept_rd, wait_done;
    logic                    store_we;
    logic [INDEX_BITS-1:0]   store_widx;
    logic [LINE_WIDTH-1:0]   store_wdata;
    logic [LINE_WIDTH-1:0]   store [0:(1<<INDEX_BITS)-1];
    logic                    unused_addr_bits;

    // Byte offset and bits above the index are dropped, so high addresses alias.
    assign rd_idx_in = mem_read_addr[INDEX_BITS+3:4];
    assign wr_idx_in = mem_write_addr[INDEX_BITS+3:4];
    assign unused_addr_bits = ^{mem_read_addr[31:INDEX_BITS+4], mem_read_addr[3:0],
                                mem_write_addr[31:INDEX_BITS+4], mem_write_addr[3:0]};

    assign accept_wr = (state == IDLE) && mem_write;
    assign accept_rd = (state == IDLE) && !mem_write && mem_read;
    // Counter is loaded with LATENCY-1 and the response state is entered as it steps to zero.
    assign wait_done = (lat_cnt <= LAT_ONE);

    assign store_we    = rst && ((accept_wr && (WR_LATENCY == 1)) ||
                                 ((state == WR_WAIT) && wait_done));
    assign store_widx  = (state == IDLE) ? wr_idx_in : wr_idx_q;
    assign store_wdata = (state == IDLE) ? mem_wr_data : wr_data_q;

    always_ff @(posedge clk) begin
        if (store_we)
            store[store_widx] <= store_wdata;
    end

    always_ff @(posedge clk) begin
        if (accept_wr) begin
            wr_idx_q  <= wr_idx_in;
            wr_data_q <= mem_wr_data;
        end
        if (accept_rd)
            rd_idx_q <= rd_idx_in;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state             <= IDLE;
            lat_cnt           <= '0;
            mem_rd_data       <= '0;
            mem_rd_data_valid <= 1'b0;
            mem_wr_data_ready <= 1'b0;
            busy              <= 1'b0;
            rd_count          <= '0;
            wr_count          <= '0;
        end else begin
            mem_rd_data_valid <= 1'b0;
            mem_wr_data_ready <= 1'b0;
            case (state)
                IDLE: begin
                    if (mem_write) begin
                        busy <= 1'b1;
                        if (WR_LATENCY == 1) begin
                            state             <= WR_RESP;
                            mem_wr_data_ready <= 1'b1;
                            wr_count          <= wr_count + 1'b1;
                        end else begin
                            state   <= WR_WAIT;
                            lat_cnt <= WR_LOAD;
                        end
                    end else if (mem_read) begin
                        busy <= 1'b1;
                        if (RD_LATENCY == 1) begin
                            state             <= RD_RESP;
                            mem_rd_data       <= store[rd_idx_in];
                            mem_rd_data_valid <= 1'b1;
                            rd_count          <= rd_count + 1'b1;
                        end else begin
                            state   <= RD_WAIT;
                            lat_cnt <= RD_LOAD;
                        end
                    end
                end
                WR_WAIT: begin
                    if (wait_done) begin
                        state             <= WR_RESP;
                        mem_wr_data_ready <= 1'b1;
                        wr_count          <= wr_count + 1'b1;
                    end else begin
                        lat_cnt <= lat_cnt - 1'b1;
                    end
                end
                RD_WAIT: begin
                    if (wait_done) begin
                        state             <= RD_RESP;
                        mem_rd_data       <= store[rd_idx_q];
                        mem_rd_data_valid <= 1'b1;
                        rd_count          <= rd_count + 1'b1;
                    end else begin
                        lat_cnt <= lat_cnt - 1'b1;
                    end
                end
                WR_RESP, RD_RESP: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_line_mem_responder.sv
// Scoreboard bench: a default-latency instance and a latency-1 / 8-bit-counter instance.
module tb_line_mem_responder;

    logic clk;
    logic rst;

    logic         a_read, a_write;
    logic [31:0]  a_raddr, a_waddr;
    logic [127:0] a_wdata, a_rdata;
    logic         a_rvld, a_wrdy, a_busy;
    logic [15:0]  a_rc, a_wc;

    logic         b_read, b_write;
    logic [31:0]  b_raddr, b_waddr;
    logic [127:0] b_wdata, b_rdata;
    logic         b_rvld, b_wrdy, b_busy;
    logic [7:0]   b_rc, b_wc;

    logic [127:0] exp_q[$];
    int n_tests = 0;
    int n_fail  = 0;

    localparam logic [127:0] D0123 = 128'h0123456789ABCDEF0123456789ABCDEF;
    localparam logic [127:0] DAA   = {16{8'hAA}};
    localparam logic [127:0] D11   = {16{8'h11}};
    localparam logic [127:0] D55   = {16{8'h55}};

    line_mem_responder #(
        .LINE_WIDTH(128), .INDEX_BITS(10), .RD_LATENCY(4), .WR_LATENCY(3), .CNT_WIDTH(16)
    ) u_dut_a (
        .clk(clk), .rst(rst),
        .mem_read(a_read), .mem_read_addr(a_raddr),
        .mem_write(a_write), .mem_write_addr(a_waddr), .mem_wr_data(a_wdata),
        .mem_rd_data(a_rdata), .mem_rd_data_valid(a_rvld), .mem_wr_data_ready(a_wrdy),
        .busy(a_busy), .rd_count(a_rc), .wr_count(a_wc)
    );

    line_mem_responder #(
        .LINE_WIDTH(128), .INDEX_BITS(10), .RD_LATENCY(1), .WR_LATENCY(1), .CNT_WIDTH(8)
    ) u_dut_b (
        .clk(clk), .rst(rst),
        .mem_read(b_read), .mem_read_addr(b_raddr),
        .mem_write(b_write), .mem_write_addr(b_waddr), .mem_wr_data(b_wdata),
        .mem_rd_data(b_rdata), .mem_rd_data_valid(b_rvld), .mem_wr_data_ready(b_wrdy),
        .busy(b_busy), .rd_count(b_rc), .wr_count(b_wc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr_line(input int sel, input logic [31:0] addr, input logic [127:0] data,
                           input int lat);
        int  cyc;
        bit  seen;
        cyc  = 0;
        seen = 0;
        if (sel == 0) begin a_write = 1'b1; a_waddr = addr; a_wdata = data; end
        else          begin b_write = 1'b1; b_waddr = addr; b_wdata = data; end
        while (!seen && cyc < 32) begin
            tick();
            cyc++;
            seen = (sel == 0) ? a_wrdy : b_wrdy;
        end
        chk("wr_seen", 128'(seen), 128'(1));
        chk("wr_latency", 128'(cyc), 128'(lat));
        chk("wr_busy_pulse", 128'((sel == 0) ? a_busy : b_busy), 128'(1));
        if (sel == 0) a_write = 1'b0; else b_write = 1'b0;
        tick();
        chk("wr_pulse_1cyc", 128'((sel == 0) ? a_wrdy : b_wrdy), 128'(0));
        chk("wr_busy_after", 128'((sel == 0) ? a_busy : b_busy), 128'(0));
    endtask

    task automatic rd_line(input int sel, input logic [31:0] addr, input logic [127:0] exp,
                           input int lat);
        int  cyc;
        bit  seen;
        logic [127:0] e;
        cyc  = 0;
        seen = 0;
        exp_q.push_back(exp);
        if (sel == 0) begin a_read = 1'b1; a_raddr = addr; end
        else          begin b_read = 1'b1; b_raddr = addr; end
        while (!seen && cyc < 32) begin
            tick();
            cyc++;
            seen = (sel == 0) ? a_rvld : b_rvld;
        end
        chk("rd_seen", 128'(seen), 128'(1));
        chk("rd_latency", 128'(cyc), 128'(lat));
        e = exp_q.pop_front();
        chk("rd_data", (sel == 0) ? a_rdata : b_rdata, e);
        if (sel == 0) a_read = 1'b0; else b_read = 1'b0;
        tick();
        chk("rd_pulse_1cyc", 128'((sel == 0) ? a_rvld : b_rvld), 128'(0));
        chk("rd_data_held", (sel == 0) ? a_rdata : b_rdata, e);
        chk("rd_busy_after", 128'((sel == 0) ? a_busy : b_busy), 128'(0));
    endtask

    initial begin
        int  cyc;
        bit  seen;
        bit  any_vld;
        logic [127:0] e;

        rst = 1'b0;
        a_read = 1'b0; a_write = 1'b0; a_raddr = '0; a_waddr = '0; a_wdata = '0;
        b_read = 1'b0; b_write = 1'b0; b_raddr = '0; b_waddr = '0; b_wdata = '0;
        repeat (3) tick();
        chk("rst_rvld", 128'(a_rvld), 128'(0));
        chk("rst_wrdy", 128'(a_wrdy), 128'(0));
        chk("rst_busy", 128'(a_busy), 128'(0));
        chk("rst_rdata", a_rdata, 128'(0));
        chk("rst_rc", 128'(a_rc), 128'(0));
        chk("rst_wc", 128'(a_wc), 128'(0));
        rst = 1'b1;
        tick();

        // Basic write then read of the same line with a different byte offset.
        wr_line(0, 32'h0000_0120, D0123, 3);
        rd_line(0, 32'h0000_012C, D0123, 4);
        chk("cnt_wc1", 128'(a_wc), 128'(1));
        chk("cnt_rc1", 128'(a_rc), 128'(1));

        // Simultaneous read and write of the same line: write first, read sees new data.
        exp_q.push_back(DAA);
        a_read = 1'b1; a_raddr = 32'h40;
        a_write = 1'b1; a_waddr = 32'h40; a_wdata = DAA;
        cyc = 0; seen = 0;
        while (!seen && cyc < 32) begin tick(); cyc++; seen = a_wrdy; end
        chk("sim_wr_seen", 128'(seen), 128'(1));
        chk("sim_wr_latency", 128'(cyc), 128'(3));
        chk("sim_rd_not_first", 128'(a_rvld), 128'(0));
        a_write = 1'b0;
        cyc = 0; seen = 0;
        while (!seen && cyc < 32) begin tick(); cyc++; seen = a_rvld; end
        chk("sim_rd_seen", 128'(seen), 128'(1));
        chk("sim_rd_after_wr", 128'(cyc), 128'(5));
        e = exp_q.pop_front();
        chk("sim_rd_data", a_rdata, e);
        a_read = 1'b0;
        tick();

        // Alias: index bits above INDEX_BITS+3 are ignored.
        wr_line(0, 32'h0000_4010, D11, 3);
        rd_line(0, 32'h0000_0010, D11, 4);

        // Captured read address is used even if the input changes after acceptance.
        exp_q.push_back(DAA);
        a_read = 1'b1; a_raddr = 32'h40;
        tick();
        a_raddr = 32'h0000_4010;
        cyc = 1; seen = a_rvld;
        while (!seen && cyc < 32) begin tick(); cyc++; seen = a_rvld; end
        chk("cap_seen", 128'(seen), 128'(1));
        chk("cap_latency", 128'(cyc), 128'(4));
        e = exp_q.pop_front();
        chk("cap_data", a_rdata, e);
        a_read = 1'b0;
        tick();

        // Asynchronous reset during RD_WAIT drops the read with no pulse.
        a_read = 1'b1; a_raddr = 32'h0000_0120;
        tick();
        tick();
        chk("rdwait_busy", 128'(a_busy), 128'(1));
        rst = 1'b0;
        #1;
        chk("arst_busy", 128'(a_busy), 128'(0));
        chk("arst_rdata", a_rdata, 128'(0));
        chk("arst_rc", 128'(a_rc), 128'(0));
        chk("arst_wc", 128'(a_wc), 128'(0));
        any_vld = 0;
        repeat (3) begin tick(); any_vld |= a_rvld; end
        a_read = 1'b0;
        rst = 1'b1;
        repeat (8) begin tick(); any_vld |= a_rvld; end
        chk("arst_no_vld", 128'(any_vld), 128'(0));
        rd_line(0, 32'h0000_0120, D0123, 4);
        chk("arst_rc_after", 128'(a_rc), 128'(1));

        // Latency-1 instance: pulse one cycle after acceptance, busy for one cycle.
        wr_line(1, 32'h0000_0050, D55, 1);
        rd_line(1, 32'h0000_0050, D55, 1);
        chk("b_wc1", 128'(b_wc), 128'(1));
        chk("b_rc1", 128'(b_rc), 128'(1));

        // 8-bit completion counter wraps: 257 reads leave it at 1.
        for (int i = 0; i < 256; i++) rd_line(1, 32'h0000_0050, D55, 1);
        chk("b_rc_wrap", 128'(b_rc), 128'(1));
        chk("sb_empty", 128'(exp_q.size()), 128'(0));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/line_mem_responder.md
Name: line_mem_responder

Overview:
- Memory-side responder for the cache controller's 128-bit line interface.
- Serves line refills (mem_read) and write-backs (mem_write) from an internal line-addressed backing store.
- Read and write latencies are programmable; responses are single-cycle pulses.
- Used as the main-memory model beneath the cache in simulation and as the FPGA on-chip memory behind it.

Parameters:
- LINE_WIDTH, 128: line data width in bits; fixed at 128 by the controller.
- INDEX_BITS, 10: backing store holds 2^INDEX_BITS lines.
- RD_LATENCY, 4: cycles from read acceptance to mem_rd_data_valid; legal range is 1 or more.
- WR_LATENCY, 3: cycles from write acceptance to mem_wr_data_ready; legal range is 1 or more.
- CNT_WIDTH, 16: width of the completion counters.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  reset, asynchronous and active-low.
- mem_read  in  1  read request; held high by the initiator until it samples mem_rd_data_valid.
- mem_read_addr  in  32  read byte address; stable while mem_read is high.
- mem_write  in  1  write request; held high until the initiator samples mem_wr_data_ready.
- mem_write_addr  in  32  write byte address; stable while mem_write is high.
- mem_wr_data  in  LINE_WIDTH  write line data; stable while mem_write is high.
- mem_rd_data  out  LINE_WIDTH  read line; valid with mem_rd_data_valid, then held.
- mem_rd_data_valid  out  1  one-cycle read completion pulse.
- mem_wr_data_ready  out  1  one-cycle write completion pulse.
- busy  out  1  high in any state other than IDLE.
- rd_count  out  CNT_WIDTH  completed reads; wraps on overflow.
- wr_count  out  CNT_WIDTH  completed writes; wraps on overflow.

Behaviour:
- Line index is addr[INDEX_BITS+3:4].
  - addr[3:0] and the address bits above the index are ignored, so out-of-range addresses alias (wrap).
- Reset (rst low):
  - Takes effect immediately; all outputs go to 0, the FSM goes to IDLE and the latency counter clears.
  - Any in-flight request is dropped with no response pulse.
  - Backing-store contents are not reset and are retained across reset.
- FSM states: IDLE, WR_WAIT, WR_RESP, RD_WAIT, RD_RESP.
- IDLE: samples requests every edge.
  - mem_write high: capture address and data, load counter with WR_LATENCY-1, go to WR_WAIT. Write has priority.
  - Else mem_read high: capture address, load counter with RD_LATENCY-1, go to RD_WAIT.
  - Simultaneous mem_read and mem_write: the write is serviced first and the read is served afterwards. A read of the same line returns the newly written data.
- WR_WAIT: decrement the counter each cycle.
  - On count 0, write the captured line to the store and go to WR_RESP.
  - If WR_LATENCY = 1, IDLE goes directly to WR_RESP and the store write happens on that edge.
- WR_RESP: mem_wr_data_ready = 1 for exactly this cycle.
  - wr_count increments.
  - Go to IDLE.
- RD_WAIT: decrement the counter.
  - On count 0, load mem_rd_data with store[index] and go to RD_RESP.
- RD_RESP: mem_rd_data_valid = 1 for exactly this cycle.
  - rd_count increments.
  - Go to IDLE.
- Timing: a request first sampled at edge E gets its response pulse in the cycle after edge E+LATENCY-1. Effective latency is LATENCY cycles.
- Captured request fields are used throughout the transaction; input changes after acceptance have no effect.
- mem_rd_data holds its last returned line until the next read response. The controller consumes it in the cycle after valid.
- A pulse-cycle request is not re-accepted. The initiator drops its request on the pulse edge, so IDLE sees it low. No back-to-back duplicate response is allowed.
- A request deasserted before its response (protocol violation) is still completed, and the pulse is still issued.
- Outputs are registered; there are no combinational input-to-output paths.

Test Plan:
- Reset, then write line 0x0123...CDEF to address 0x0000_0120; then read 0x0000_012C → mem_wr_data_ready pulses 3 cycles after acceptance. mem_rd_data_valid pulses 4 cycles after acceptance with the same 128-bit value. wr_count=1, rd_count=1.
- mem_read and mem_write asserted in the same cycle to address 0x40, write data 0xAA..AA → ready pulse first. The read is accepted next in IDLE and returns 0xAA..AA.
- Write 0x11..11 to 0x0000_4010 (INDEX_BITS=10), then read 0x0000_0010 → returns 0x11..11 (alias wrap).
- Drive rst low during RD_WAIT → outputs 0 immediately and no valid pulse appears. After release, a read of the earlier-written line still returns its data.
- Parameter sweep RD_LATENCY=1 and WR_LATENCY=1 → each pulse appears 1 cycle after acceptance, and busy is high for exactly 1 cycle. Hold mem_read_addr changing after acceptance → the originally captured line is returned.
- Issue 65537 reads with CNT_WIDTH=16 → rd_count wraps to 1.
